// File: rtl/fabric_ingress_arbiter.sv
// fabric_ingress_arbiter: frame-atomic round-robin arbiter from per-port buffers onto the fabric ingress bus
module fabric_ingress_arbiter #(
  parameter int NUM_PORTS  = 24,
  parameter int DATA_WIDTH = 32,
  parameter int PORT_BITS  = 5,
  parameter int MAX_BEATS  = 384
) (
  input  logic                            clk_fabric,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_enable,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_last,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [PORT_BITS-1:0]            out_port,
  input  logic                            out_ready,
  output logic                            truncated
);
  localparam int CW = $clog2(MAX_BEATS);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state;
  logic [PORT_BITS-1:0] rr_ptr, grant, pick, off, next_ptr;
  logic [PORT_BITS:0] sum;
  logic [CW-1:0] beat_cnt;
  logic [NUM_PORTS-1:0] cand, rot, gmask;
  logic found, g_valid, g_last, at_max, active, xfer;
  logic [DATA_WIDTH-1:0] g_data;
  assign cand = req_valid & port_enable;
  assign found = |cand;
  // rotate candidates so bit 0 is rr_ptr, then take the lowest set offset
  always_comb begin
    rot = NUM_PORTS'({cand, cand} >> rr_ptr);
    off = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) off = rot[k] ? PORT_BITS'(k) : off;
    sum = {1'b0, rr_ptr} + {1'b0, off};
    pick = (sum >= (PORT_BITS+1)'(NUM_PORTS)) ? PORT_BITS'(sum - (PORT_BITS+1)'(NUM_PORTS)) : PORT_BITS'(sum);
  end
  assign g_valid = req_valid[grant];
  assign g_last = req_last[grant];
  assign g_data = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign gmask = NUM_PORTS'(1) << grant;
  assign at_max = beat_cnt == CW'(MAX_BEATS-1);
  assign active = state == ACTIVE;
  assign out_valid = active & g_valid;
  assign out_last = active & (g_last | at_max);
  assign out_data = active ? g_data : '0;
  assign req_ready = ((active & out_ready) | (state == DRAIN)) ? gmask : '0;
  assign xfer = out_valid & out_ready;
  assign next_ptr = (grant == PORT_BITS'(NUM_PORTS-1)) ? '0 : grant + 1'b1;
  always_ff @(posedge clk_fabric or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      beat_cnt <= '0;
      out_port <= '0;
      truncated <= 1'b0;
    end else begin
      truncated <= 1'b0;
      case (state)
        IDLE: if (found) begin
          grant <= pick;
          out_port <= pick;
          beat_cnt <= '0;
          state <= ACTIVE;
        end
        ACTIVE: if (xfer) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (g_last) begin
            state <= IDLE;
            rr_ptr <= next_ptr;
          end else if (at_max) begin
            truncated <= 1'b1;
            state <= DRAIN;
          end
        end
        DRAIN: if (g_valid & g_last) begin
          state <= IDLE;
          rr_ptr <= next_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fabric_ingress_arbiter.sv
// tb_fabric_ingress_arbiter: directed vector and sequence checks for fabric_ingress_arbiter
module tb_fabric_ingress_arbiter;
  localparam int N = 24, DW = 32, PB = 5, MB = 384;
  logic clk_fabric = 1'b0, rst_n;
  logic [N-1:0] port_enable, req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic out_valid, out_last, out_ready, truncated;
  logic [DW-1:0] out_data;
  logic [PB-1:0] out_port;

  fabric_ingress_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .PORT_BITS(PB), .MAX_BEATS(MB)) dut (
    .clk_fabric(clk_fabric), .rst_n(rst_n), .port_enable(port_enable), .req_valid(req_valid),
    .req_last(req_last), .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_last(out_last), .out_data(out_data), .out_port(out_port), .out_ready(out_ready),
    .truncated(truncated));

  always #5 clk_fabric = ~clk_fabric;

  typedef struct {int port; int data; bit last; int cyc;} beat_t;
  typedef struct {logic [N-1:0] req; logic [N-1:0] en; int exp;} vec_t;
  beat_t beats[$];
  vec_t tv[11];
  int rem[N], nfr[N], flen[N], fno[N], idx[N];
  int nchk = 0, nerr = 0, ncyc = 0, nlast = 0, ntrunc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {req_ready, out_valid, out_last, out_data, out_port, truncated};
  endfunction

  function automatic int bp(input int i);
    return (i < beats.size()) ? beats[i].port : -1;
  endfunction

  function automatic int bc(input int i);
    return (i < beats.size()) ? beats[i].cyc : -1;
  endfunction

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      req_valid[p] = rem[p] > 0;
      req_last[p] = rem[p] == 1;
      req_data[p*DW +: DW] = {8'(p), 8'(fno[p]), 16'(idx[p])};
    end
  endtask

  task automatic start(input int p, input int len, input int n);
    flen[p] = len; rem[p] = len; nfr[p] = n; idx[p] = 0; fno[p] = 0;
    drive();
  endtask

  task automatic clear_src();
    for (int p = 0; p < N; p++) begin
      rem[p] = 0; nfr[p] = 0; idx[p] = 0; fno[p] = 0;
    end
    drive();
  endtask

  task automatic advance(input int p);
    idx[p]++;
    rem[p]--;
    if (rem[p] == 0) begin
      if (nfr[p] > 1) begin
        nfr[p]--; rem[p] = flen[p]; idx[p] = 0; fno[p]++;
      end else nfr[p] = 0;
    end
  endtask

  task automatic cyc();
    logic [N-1:0] fire;
    @(negedge clk_fabric);
    fire = req_valid & req_ready;
    if (out_valid && out_ready) begin
      beats.push_back('{int'(out_port), int'(out_data), out_last, ncyc});
      if (out_last) nlast++;
    end
    if (truncated) ntrunc++;
    ncyc++;
    @(posedge clk_fabric);
    #1;
    for (int p = 0; p < N; p++) if (fire[p]) advance(p);
    drive();
  endtask

  task automatic run_frames(input int n, input int bound);
    int target = nlast + n;
    int k = 0;
    while (nlast < target && k < bound) begin
      cyc();
      k++;
    end
    if (nlast < target) begin
      nchk++; nerr++;
      $display("FAIL timeout: got %0d frames expected %0d", nlast - target + n, n);
    end
  endtask

  task automatic check_frame(input string nm, input int s, input int p, input int len);
    bit ok = 1'b1;
    if (beats.size() < s + len) ok = 1'b0;
    else for (int i = 0; i < len; i++) begin
      beat_t e = beats[s+i];
      if (e.port != p || e.data[15:0] != 16'(i) || e.data[31:24] != 8'(p) || e.last != (i == len-1)) ok = 1'b0;
    end
    chk({nm, "_frame"}, 64'(ok), 64'd1);
  endtask

  initial begin
    int s, s2, c0, t0, k;
    int exp_b[5] = '{0, 5, 23, 0, 5};
    bit pat[10] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
    tv[0]  = '{24'h800021, 24'hFFFFFF, 5};
    tv[1]  = '{24'h800021, 24'hFFFFFF, 23};
    tv[2]  = '{24'h800021, 24'hFFFFFF, 0};
    tv[3]  = '{24'h800021, 24'hFFFFFF, 5};
    tv[4]  = '{24'h000050, 24'hFFFFEF, 6};
    tv[5]  = '{24'h000084, 24'hFFFFFF, 7};
    tv[6]  = '{24'h800004, 24'h000004, 2};
    tv[7]  = '{24'h000002, 24'h000000, -1};
    tv[8]  = '{24'h00000F, 24'hFFFFFF, 3};
    tv[9]  = '{24'h000001, 24'hFFFFFF, 0};
    tv[10] = '{24'h800002, 24'hFFFFFF, 1};
    rst_n = 1'b0; out_ready = 1'b1; port_enable = '1;
    clear_src();
    repeat (2) @(posedge clk_fabric);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    c0 = ncyc; s = beats.size();
    start(3, 4, 1);
    run_frames(1, 20);
    chk("a_latency", 64'(bc(s) - c0), 64'd1);
    chk("a_beats", 64'(beats.size() - s), 64'd4);
    check_frame("a", s, 3, 4);
    for (int v = 0; v < 11; v++) begin
      port_enable = tv[v].en;
      s = beats.size();
      for (int p = 0; p < N; p++) if (tv[v].req[p]) start(p, 2, 1);
      if (tv[v].exp < 0) begin
        repeat (8) cyc();
        chk($sformatf("vec%0d_idle", v), 64'(beats.size() - s), 64'd0);
      end else begin
        run_frames(1, 20);
        chk($sformatf("vec%0d_grant", v), 64'(bp(s)), 64'(tv[v].exp));
        chk($sformatf("vec%0d_beats", v), 64'(beats.size() - s), 64'd2);
        check_frame($sformatf("vec%0d", v), s, tv[v].exp, 2);
      end
      clear_src();
    end
    port_enable = '1;
    s = beats.size(); t0 = ntrunc; k = 0;
    start(7, 400, 1);
    while (rem[7] > 0 && k < 1000) begin
      cyc();
      k++;
    end
    cyc();
    chk("c_drained", 64'(rem[7]), 64'd0);
    chk("c_beats", 64'(beats.size() - s), 64'(MB));
    check_frame("c", s, 7, MB);
    chk("c_trunc", 64'(ntrunc - t0), 64'd1);
    s = beats.size(); t0 = ntrunc;
    start(8, MB, 1);
    run_frames(1, 600);
    cyc();
    chk("c2_beats", 64'(beats.size() - s), 64'(MB));
    check_frame("c2", s, 8, MB);
    chk("c2_no_trunc", 64'(ntrunc - t0), 64'd0);
    s = beats.size();
    start(2, 6, 1);
    cyc();
    for (int i = 0; i < 10 && rem[2] > 0; i++) begin
      out_ready = pat[i];
      #1;
      chk($sformatf("d_ready%0d", i), 64'(req_ready), out_ready ? 64'h4 : 64'h0);
      cyc();
    end
    out_ready = 1'b1;
    chk("d_beats", 64'(beats.size() - s), 64'd6);
    check_frame("d", s, 2, 6);
    port_enable = 24'hFFFFEF;
    s = beats.size(); k = 0;
    start(4, 4, 1);
    start(6, 4, 1);
    while (beats.size() < s + 2 && k < 20) begin
      cyc();
      k++;
    end
    port_enable = 24'hFFFFAF;
    run_frames(1, 20);
    check_frame("e6", s, 6, 4);
    s2 = beats.size();
    repeat (6) cyc();
    chk("e_no_grant4", 64'(beats.size() - s2), 64'd0);
    port_enable = '1;
    run_frames(1, 20);
    check_frame("e4", s2, 4, 4);
    s = beats.size(); k = 0;
    start(9, 10, 1);
    while (beats.size() < s + 3 && k < 20) begin
      cyc();
      k++;
    end
    #2 rst_n = 1'b0;
    #1 chk("f_async_reset", outs(), 64'd0);
    clear_src();
    repeat (2) @(posedge clk_fabric);
    #1 rst_n = 1'b1;
    c0 = ncyc; s = beats.size();
    start(0, 2, 3);
    start(5, 2, 3);
    start(23, 2, 3);
    run_frames(5, 60);
    clear_src();
    chk("b_first_latency", 64'(bc(s) - c0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_frame($sformatf("b%0d", i), s + 2*i, exp_b[i], 2);
      if (i > 0) chk($sformatf("b%0d_bubble", i), 64'(bc(s + 2*i) - bc(s + 2*i - 1)), 64'd2);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fabric_ingress_arbiter.md
Name: fabric_ingress_arbiter

Overview:
- Frame-atomic round-robin arbiter between the per-port line card input buffers (fabric clock side) and the single shared fabric ingress bus.
- Grants one port at a time and forwards that port's whole frame, tagged with its source port number.
- Enforces a maximum frame length. Overlong frames are truncated on the bus and their tail is drained from the source buffer.

Parameters:
NUM_PORTS, 24, number of requesting ports
DATA_WIDTH, 32, beat width in bits
PORT_BITS, 5, width of port index (>= clog2(NUM_PORTS))
MAX_BEATS, 384, maximum beats forwarded per frame; beat MAX_BEATS is forced last

Ports:
clk_fabric  input  1  fabric clock
rst_n  input  1  asynchronous active-low reset
port_enable  input  NUM_PORTS  per-port eligibility mask, sampled only in IDLE
req_valid  input  NUM_PORTS  per-port beat valid
req_last  input  NUM_PORTS  per-port end-of-frame
req_data  input  NUM_PORTS*DATA_WIDTH  per-port beat data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_PORTS  per-port ready, one-hot or zero
out_valid  output  1  fabric bus beat valid
out_last  output  1  fabric bus end-of-frame
out_data  output  DATA_WIDTH  fabric bus data
out_port  output  PORT_BITS  source port of the current frame, stable for the whole frame
out_ready  input  1  fabric bus backpressure
truncated  output  1  one-cycle pulse when a frame is cut at MAX_BEATS

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - All outputs 0: req_ready=0, out_valid=0, out_last=0, out_data=0, out_port=0, truncated=0.
  - A frame in flight is abandoned. Upstream buffers are not informed.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - Candidates = req_valid & port_enable.
  - If any candidate exists, pick the first index at or after rr_ptr, wrapping modulo NUM_PORTS.
  - Register grant and out_port, clear beat_cnt, and enter ACTIVE next cycle.
  - No beat is transferred in IDLE, so each frame costs exactly 1 arbitration bubble cycle.
  - No candidates -> remain in IDLE.
- ACTIVE (combinational mux on registered grant):
  - out_valid = req_valid[grant], out_data = req_data[grant].
  - out_last = req_last[grant] | (beat_cnt == MAX_BEATS-1).
  - req_ready[grant] = out_ready; all other req_ready = 0.
  - A beat transfers when out_valid & out_ready. Each transfer increments beat_cnt.
- Normal frame end: a transfer with req_last[grant] -> IDLE; rr_ptr = grant+1, wrapping NUM_PORTS-1 -> 0.
- Truncation: a transfer with beat_cnt == MAX_BEATS-1 and req_last[grant]=0:
  - truncated pulses for 1 cycle.
  - State -> DRAIN.
- DRAIN:
  - out_valid=0; req_ready[grant]=1 regardless of out_ready.
  - Source beats are discarded until a beat with req_valid & req_last is accepted.
  - Then -> IDLE, rr_ptr = grant+1.
- If the MAX_BEATS-th beat also carries req_last, the frame ends normally with no truncated pulse.
- port_enable changes during ACTIVE/DRAIN do not affect the current frame. They take effect at the next IDLE decision.
- req_valid dropping mid-frame stalls the bus (out_valid=0) and grant is held. There is no timeout.
- out_ready low holds the beat; out_data/out_last are stable because the source must hold them per the handshake.
- beat_cnt width is clog2(MAX_BEATS) and never wraps.
- Worst-case wait for any enabled, continuously requesting port: NUM_PORTS-1 frames.

Test Plan:
- Reset, then port 3 sends a 4-beat frame with out_ready=1 -> first out_valid 1 cycle after IDLE decision; 4 beats with out_port=3, out_last on beat 4; rr_ptr=4 afterwards.
- Ports 0, 5 and 23 all request continuously with 2-beat frames, rr_ptr=0 -> grant order 0, 5, 23, 0, 5; 1 bubble cycle between frames.
- Port 7 sends a 400-beat frame, MAX_BEATS=384 -> 384 beats out with out_last on beat 384 and truncated pulsing once; the remaining 16 beats accepted with out_valid=0; then IDLE.
- Port 2 mid-frame with out_ready toggling 1,0,0,1 -> req_ready[2] mirrors out_ready; no beat lost or duplicated; data order preserved.
- port_enable[4]=0 while port 4 requests alongside port 6 -> only port 6 is granted; clearing port_enable[6] mid-frame still completes port 6's frame.
- rst_n asserted on beat 3 of a 10-beat frame -> all outputs 0 immediately; after release, arbitration restarts with rr_ptr=0.
